mips_axi_ram_slave: RTL and testbench

- AXI4-Lite single-beat memory slave; the downstream consumer of the MIPS CPU top-level AXI master (AR/R for fetch and load, AW/W/B for store).
- Holds instruction and data memory in one word-organised synchronous RAM.
- Independent read and write engines serve both paths.
- Returns SLVERR for addresses outside the implemented window.

---
 rtl/mips_axi_ram_slave_pkg.sv | 20 ++
 rtl/mips_axi_ram_slave_if.sv | 32 +++
 rtl/mips_axi_ram_slave_bram.sv | 32 +++
 rtl/mips_axi_ram_slave.sv | 171 +++++++++++++++++
 tb/tb_mips_axi_ram_slave.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_axi_ram_slave_pkg.sv
// Shared definitions for the AXI4-Lite RAM slave: response codes, FSM states
// and the byte-lane merge used by the RAM write port.
package mips_axi_ram_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP}  rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WRITE, W_RESP} wr_state_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++)
         merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
      return merged;
   endfunction

endpackage

// File: rtl/mips_axi_ram_slave_if.sv
// AXI4-Lite bus between the MIPS CPU master and the RAM slave.
interface mips_axi_ram_if;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface

// File: rtl/mips_axi_ram_slave_bram.sv
// Word-organised simple dual-port RAM: one synchronous read port, one
// byte-enabled write port, read-first on a same-word collision.
module mips_axi_ram_bram
   import mips_axi_ram_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter     INIT_FILE  = ""
) (
   input  logic                  i_clk,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [31:0]           o_rdata,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [31:0]           i_wdata,
   input  logic [3:0]            i_wbe
);

   logic [31:0] r_mem [2**ADDR_WIDTH];
   logic [31:0] r_rdata;

   // Both ports use non-blocking updates, so a colliding read sees the old word.
   always_ff @(posedge i_clk) begin
      if (i_re)
         r_rdata <= r_mem[i_raddr];
      if (i_we)
         r_mem[i_waddr] <= strb_merge(r_mem[i_waddr], i_wdata, i_wbe);
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_axi_ram_slave.sv
// AXI4-Lite single-beat RAM slave serving the MIPS CPU fetch/load/store paths
// with independent read and write engines over one shared RAM.
module mips_axi_ram_slave
   import mips_axi_ram_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter     INIT_FILE  = ""
) (
   input  logic          mips_cpu_clk,
   input  logic          mips_cpu_reset,
   mips_axi_ram_if.slave mem_axi
);

   // ---------------- read engine ----------------
   rd_state_t             r_rd_state;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [31:0]           r_rdata;
   logic [1:0]            r_rresp;
   logic                  r_ar_err;

   logic                  w_ar_hs;
   logic                  w_ar_err;
   logic [ADDR_WIDTH-1:0] w_ar_idx;
   logic [31:0]           w_ram_rdata;

   assign w_ar_idx = mem_axi.araddr[ADDR_WIDTH+1:2];
   assign w_ar_err = |mem_axi.araddr[31:ADDR_WIDTH+2];
   assign w_ar_hs  = mem_axi.arvalid & r_arready;

   always_ff @(posedge mips_cpu_clk) begin
      if (mips_cpu_reset) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_rresp    <= RESP_OKAY;
         r_ar_err   <= 1'b0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               r_arready <= ~w_ar_hs;
               if (w_ar_hs) begin
                  r_ar_err   <= w_ar_err;
                  r_rd_state <= R_MEM;
               end
            end
            R_MEM: begin
               r_rdata    <= r_ar_err ? '0 : w_ram_rdata;
               r_rresp    <= r_ar_err ? RESP_SLVERR : RESP_OKAY;
               r_rvalid   <= 1'b1;
               r_rd_state <= R_RESP;
            end
            R_RESP: begin
               if (mem_axi.rready) begin
                  r_rvalid   <= 1'b0;
                  r_arready  <= 1'b1;
                  r_rd_state <= R_IDLE;
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   // ---------------- write engine ----------------
   wr_state_t             r_wr_state;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_aw_got;
   logic                  r_w_got;
   logic [ADDR_WIDTH-1:0] r_aw_idx;
   logic                  r_aw_err;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_aw_have;
   logic                  w_w_have;
   logic                  w_ram_we;

   assign w_aw_hs   = mem_axi.awvalid & r_awready;
   assign w_w_hs    = mem_axi.wvalid & r_wready;
   assign w_aw_have = r_aw_got | w_aw_hs;
   assign w_w_have  = r_w_got | w_w_hs;

   always_ff @(posedge mips_cpu_clk) begin
      if (mips_cpu_reset) begin
         r_wr_state <= W_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_aw_got   <= 1'b0;
         r_w_got    <= 1'b0;
         r_aw_idx   <= '0;
         r_aw_err   <= 1'b0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               // AW and W are captured independently; each ready drops once its channel is held.
               if (w_aw_hs) begin
                  r_aw_idx <= mem_axi.awaddr[ADDR_WIDTH+1:2];
                  r_aw_err <= |mem_axi.awaddr[31:ADDR_WIDTH+2];
               end
               if (w_w_hs) begin
                  r_wdata <= mem_axi.wdata;
                  r_wstrb <= mem_axi.wstrb;
               end
               r_aw_got  <= w_aw_have;
               r_w_got   <= w_w_have;
               r_awready <= ~w_aw_have;
               r_wready  <= ~w_w_have;
               if (w_aw_have & w_w_have)
                  r_wr_state <= W_WRITE;
            end
            W_WRITE: begin
               r_bresp    <= r_aw_err ? RESP_SLVERR : RESP_OKAY;
               r_bvalid   <= 1'b1;
               r_wr_state <= W_RESP;
            end
            W_RESP: begin
               if (mem_axi.bready) begin
                  r_bvalid   <= 1'b0;
                  r_aw_got   <= 1'b0;
                  r_w_got    <= 1'b0;
                  r_awready  <= 1'b1;
                  r_wready   <= 1'b1;
                  r_wr_state <= W_IDLE;
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   assign w_ram_we = (r_wr_state == W_WRITE) & ~r_aw_err;

   mips_axi_ram_bram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_bram (
      .i_clk   (mips_cpu_clk),
      .i_re    (w_ar_hs & ~w_ar_err),
      .i_raddr (w_ar_idx),
      .o_rdata (w_ram_rdata),
      .i_we    (w_ram_we),
      .i_waddr (r_aw_idx),
      .i_wdata (r_wdata),
      .i_wbe   (r_wstrb)
   );

   assign mem_axi.arready = r_arready;
   assign mem_axi.rvalid  = r_rvalid;
   assign mem_axi.rdata   = r_rdata;
   assign mem_axi.rresp   = r_rresp;
   assign mem_axi.awready = r_awready;
   assign mem_axi.wready  = r_wready;
   assign mem_axi.bvalid  = r_bvalid;
   assign mem_axi.bresp   = r_bresp;

   // Byte offset within a word carries no meaning for a word-wide slave.
   logic w_unused;
   assign w_unused = &{1'b0, mem_axi.araddr[1:0], mem_axi.awaddr[1:0]};

endmodule

// File: tb/tb_mips_axi_ram_slave.sv
// Directed bench for the AXI4-Lite RAM slave; inputs driven and outputs
// sampled on the falling clock edge.
module tb_mips_axi_ram_slave;
   import mips_axi_ram_slave_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   mips_axi_ram_if bus();

   mips_axi_ram_slave #(.ADDR_WIDTH(12), .INIT_FILE("")) dut (
      .mips_cpu_clk   (clk),
      .mips_cpu_reset (rst),
      .mem_axi        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int aw_dly, input int w_dly, output logic [1:0] resp);
      bit aw_done = 0, w_done = 0, aw_now, w_now, got_b = 0;
      int cyc = 0;
      resp = 2'bxx;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge clk);
         bus.awvalid = !aw_done && cyc >= aw_dly;
         bus.wvalid  = !w_done && cyc >= w_dly;
         aw_now = bus.awvalid && bus.awready;
         w_now  = bus.wvalid && bus.wready;
         @(posedge clk);
         aw_done |= aw_now;
         w_done  |= w_now;
         cyc++;
      end
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
      for (int i = 0; i < 20 && !got_b; i++) begin
         if (bus.bvalid) begin
            got_b = 1;
            resp  = bus.bresp;
            @(negedge clk);
            chk("bvalid_drop", 32'(bus.bvalid), 0);
         end else
            @(negedge clk);
      end
      if (!got_b) chk("b_timeout", 0, 1);
   endtask

   task automatic axi_rd(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
      bit hs = 0, got = 0;
      lat  = -1;
      data = 'x;
      resp = 'x;
      bus.araddr = addr;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk);
         bus.arvalid = 1'b1;
         hs = bus.arready;
      end
      @(negedge clk);
      bus.arvalid = 1'b0;
      for (int i = 1; i < 20 && !got; i++) begin
         if (bus.rvalid) begin
            got  = 1;
            lat  = i;
            data = bus.rdata;
            resp = bus.rresp;
         end
         @(negedge clk);
      end
      if (!hs || !got) chk("rd_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      int          lat;
      int          bad;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 32'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                           bus.rresp, bus.bresp}), 0);
      chk("rst_rdata", bus.rdata, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);

      // write then read back with latency check
      axi_wr(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r);
      chk("wr10_bresp", 32'(r), 32'(RESP_OKAY));
      axi_rd(32'h10, d, r, lat);
      chk("rd10_data", d, 32'hDEADBEEF);
      chk("rd10_resp", 32'(r), 32'(RESP_OKAY));
      chk("rd10_lat", 32'(lat), 2);

      // AW before W by three cycles
      axi_wr(32'h20, 32'h11223344, 4'hF, 0, 3, r);
      chk("aw_first_bresp", 32'(r), 32'(RESP_OKAY));
      axi_rd(32'h20, d, r, lat);
      chk("aw_first_data", d, 32'h11223344);

      // W before AW, partial strobe
      axi_wr(32'h20, 32'hAABBCCDD, 4'b0101, 2, 0, r);
      chk("strb_bresp", 32'(r), 32'(RESP_OKAY));
      axi_rd(32'h20, d, r, lat);
      chk("strb_data", d, 32'h11BB33DD);

      // zero strobe is a no-op
      axi_wr(32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, r);
      chk("nostrb_bresp", 32'(r), 32'(RESP_OKAY));
      axi_rd(32'h20, d, r, lat);
      chk("nostrb_data", d, 32'h11BB33DD);

      // out of range: 0x4000 aliases word 0 in the index bits only
      axi_wr(32'h0, 32'h01020304, 4'hF, 0, 0, r);
      axi_wr(32'h4000, 32'h99999999, 4'hF, 0, 0, r);
      chk("oor_bresp", 32'(r), 32'(RESP_SLVERR));
      axi_rd(32'h0, d, r, lat);
      chk("oor_ram_kept", d, 32'h01020304);
      axi_rd(32'h4000, d, r, lat);
      chk("oor_rdata", d, 0);
      chk("oor_rresp", 32'(r), 32'(RESP_SLVERR));
      axi_rd(32'hFFFFFFFC, d, r, lat);
      chk("oor_top_rresp", 32'(r), 32'(RESP_SLVERR));

      // last word in range, unaligned read address
      axi_wr(32'h3FFC, 32'hCAFEF00D, 4'hF, 0, 0, r);
      chk("top_bresp", 32'(r), 32'(RESP_OKAY));
      axi_rd(32'h3FFF, d, r, lat);
      chk("top_data", d, 32'hCAFEF00D);
      chk("top_rresp", 32'(r), 32'(RESP_OKAY));

      // read colliding with a write commit, then backpressure
      axi_wr(32'h30, 32'h55555555, 4'hF, 0, 0, r);
      bus.rready  = 1'b0;
      bus.awaddr  = 32'h30; bus.wdata = 32'h66666666; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1;   bus.wvalid = 1'b1;
      chk("bp_wr_ready", 32'({bus.awready, bus.wready}), 3);
      @(negedge clk);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr  = 32'h30; bus.arvalid = 1'b1;
      chk("bp_arready", 32'(bus.arready), 1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      @(negedge clk);
      chk("bp_rvalid", 32'(bus.rvalid), 1);
      chk("bp_old_data", bus.rdata, 32'h55555555);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (!bus.rvalid || bus.rdata !== 32'h55555555 || bus.arready) bad++;
      end
      chk("bp_stable", 32'(bad), 0);
      bus.rready = 1'b1;
      @(negedge clk);
      chk("bp_release", 32'({bus.rvalid, bus.arready}), 1);
      axi_rd(32'h30, d, r, lat);
      chk("bp_new_data", d, 32'h66666666);

      // reset with AW held but no W
      axi_wr(32'h40, 32'h12345678, 4'hF, 0, 0, r);
      bus.awaddr = 32'h40; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1;
      @(negedge clk);
      chk("mid_aw_taken", 32'({bus.awready, bus.wready}), 1);
      bus.awvalid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctrl", 32'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid,
                               bus.rresp, bus.bresp}), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_ready", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);
      bus.wvalid = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.bvalid) bad++;
      end
      chk("mid_no_b", 32'(bad), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      axi_rd(32'h40, d, r, lat);
      chk("mid_ram_kept", d, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
